// File: rtl/tt_um_jleugeri_ttt_event_drain_pkg.sv
// Shared definitions for the event-drain block.
//   state_t      : drain FSM states (IDLE, EMIT)
//   DEFAULT_SIZE : default event-vector width
//   idx_width()  : number of bits needed to index a vector of a given width
package tt_um_jleugeri_ttt_event_drain_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int DEFAULT_SIZE = 8;

  // Never below 1, so a bit index always has at least one wire.
  function automatic int idx_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  localparam int DEFAULT_IDX_W = idx_width(DEFAULT_SIZE);

endpackage

// File: rtl/tt_um_jleugeri_ttt_lsb_find.sv
// Combinational lowest-set-bit finder.
// Ports:
//   bits     (in)  : vector to scan
//   idx      (out) : index of the lowest set bit (0 when bits is empty)
//   nonempty (out) : at least one bit set
//   single   (out) : exactly one bit set
module tt_um_jleugeri_ttt_lsb_find
  import tt_um_jleugeri_ttt_event_drain_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE,
  localparam int IW = idx_width(SIZE)
) (
  input  logic [SIZE-1:0] bits,
  output logic [IW-1:0]   idx,
  output logic            nonempty,
  output logic            single
);

  // Scan from the top down so the last hit (the lowest set bit) wins.
  always_comb begin
    idx = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (bits[i]) idx = IW'(i);
    end
  end

  assign nonempty = |bits;
  // Clearing the lowest set bit leaves zero only for a one-hot vector.
  assign single   = nonempty && ((bits & (bits - SIZE'(1))) == '0);

endmodule

// File: rtl/tt_um_jleugeri_ttt_event_drain.sv
// Event drain: snapshots an event bit vector on load and emits the index of
// each set bit, lowest first, over a valid/ready handshake.
// Optional feature: define RESPITE_EVENT_COUNT_EN to make count report the
// number of indices emitted since the last accepted load (saturating at
// SIZE); otherwise count is tied to zero and no counter exists.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   in, load    : event vector and snapshot request (accepted only in IDLE)
//   busy        : a snapshot is being drained
//   out_valid   : out_idx holds a pending index
//   out_ready   : consumer accepts out_idx
//   out_idx     : lowest pending set-bit index (0 when not valid)
//   out_last    : current index is the final pending bit
//   done        : one-cycle pulse after a drain completes
//   count       : indices emitted since the last load (or 0)
module tt_um_jleugeri_ttt_event_drain
  import tt_um_jleugeri_ttt_event_drain_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SIZE-1:0]          in,
  input  logic                     load,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(SIZE)-1:0]  out_idx,
  output logic                     out_last,
  output logic                     done,
  output logic [$clog2(SIZE):0]    count
);

  localparam int IW = idx_width(SIZE);
  localparam int CW = $clog2(SIZE) + 1;

  state_t           state_reg, state_next;
  logic [SIZE-1:0]  pending_reg, pending_next;
  logic             done_reg, done_next;

  logic [IW-1:0]    low_idx;
  logic             nonempty;
  logic             single;
  logic             handshake;
  logic             load_accept;

  tt_um_jleugeri_ttt_lsb_find #(
    .SIZE (SIZE)
  ) u_lsb_find (
    .bits     (pending_reg),
    .idx      (low_idx),
    .nonempty (nonempty),
    .single   (single)
  );

  assign busy        = (state_reg == EMIT);
  assign out_valid   = busy;
  assign out_idx     = out_valid ? low_idx : '0;
  assign out_last    = out_valid & single;
  assign done        = done_reg;
  assign handshake   = out_valid & out_ready;
  assign load_accept = (state_reg == IDLE) & load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load) begin
          pending_next = in;
          if (|in) begin
            state_next = EMIT;
          end else begin
            // Empty snapshot: nothing to emit, report completion at once.
            done_next = 1'b1;
          end
        end
      end
      EMIT: begin
        if (!nonempty) begin
          // Unreachable in normal operation; recover quietly to IDLE.
          state_next = IDLE;
        end else if (handshake) begin
          pending_next = pending_reg & ~(SIZE'(1) << low_idx);
          if (single) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef RESPITE_EVENT_COUNT_EN
  logic [CW-1:0] count_reg, count_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  always_comb begin
    count_next = count_reg;
    if (load_accept) begin
      count_next = '0;
    end else if (handshake && (count_reg != CW'(SIZE))) begin
      count_next = count_reg + 1'b1;
    end
  end

  assign count = count_reg;
`else
  logic unused_load_accept;
  assign unused_load_accept = load_accept;
  assign count = '0;
`endif

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_event_drain.sv
// Directed self-checking bench for the event drain (SIZE = 8).
module tb_tt_um_jleugeri_ttt_event_drain;

  logic       clk;
  logic       rst_n;
  logic [7:0] in;
  logic       load;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       done;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  tt_um_jleugeri_ttt_event_drain #(
    .SIZE (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .load      (load),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .done      (done),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected count: the counter only exists when the feature is enabled.
  function automatic logic [3:0] ec(input int n);
`ifdef RESPITE_EVENT_COUNT_EN
    return 4'(n);
`else
    return 4'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the full output set in one line per transaction.
  task automatic chk_all(input string tag, input logic v, input logic [2:0] idx,
                         input logic last, input logic dn, input logic [3:0] cnt);
    $display("%s: valid=%0b idx=%0d last=%0b done=%0b busy=%0b count=%0d",
             tag, out_valid, out_idx, out_last, done, busy, count);
    chk({tag, ".valid"}, {7'd0, out_valid}, {7'd0, v});
    chk({tag, ".busy"},  {7'd0, busy},      {7'd0, v});
    chk({tag, ".idx"},   {5'd0, out_idx},   {5'd0, idx});
    chk({tag, ".last"},  {7'd0, out_last},  {7'd0, last});
    chk({tag, ".done"},  {7'd0, done},      {7'd0, dn});
    chk({tag, ".count"}, {4'd0, count},     {4'd0, cnt});
  endtask

  // Advance one clock edge, then let outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in = 8'h00; load = 1'b0; out_ready = 1'b0;
    #1;
    chk_all("reset", 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk_all("idle", 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);

    // Drain 1010_0100 at full rate.
    in = 8'hA4; load = 1'b1; out_ready = 1'b1;
    step(); load = 1'b0; in = 8'h00;
    chk_all("a4_i2", 1'b1, 3'd2, 1'b0, 1'b0, ec(0));
    step(); chk_all("a4_i5", 1'b1, 3'd5, 1'b0, 1'b0, ec(1));
    step(); chk_all("a4_i7", 1'b1, 3'd7, 1'b1, 1'b0, ec(2));
    step(); chk_all("a4_done", 1'b0, 3'd0, 1'b0, 1'b1, ec(3));
    step(); chk_all("a4_after", 1'b0, 3'd0, 1'b0, 1'b0, ec(3));

    // Same vector with backpressure for four cycles.
    in = 8'hA4; load = 1'b1; out_ready = 1'b0;
    step(); load = 1'b0; in = 8'h00;
    chk_all("bp_c1", 1'b1, 3'd2, 1'b0, 1'b0, ec(0));
    step(); chk_all("bp_c2", 1'b1, 3'd2, 1'b0, 1'b0, ec(0));
    step(); chk_all("bp_c3", 1'b1, 3'd2, 1'b0, 1'b0, ec(0));
    step(); chk_all("bp_c4", 1'b1, 3'd2, 1'b0, 1'b0, ec(0));
    out_ready = 1'b1;
    step(); chk_all("bp_i5", 1'b1, 3'd5, 1'b0, 1'b0, ec(1));
    step(); chk_all("bp_i7", 1'b1, 3'd7, 1'b1, 1'b0, ec(2));
    step(); chk_all("bp_done", 1'b0, 3'd0, 1'b0, 1'b1, ec(3));

    // Empty snapshot: no valid, done the cycle after the load edge.
    in = 8'h00; load = 1'b1;
    step(); load = 1'b0;
    chk_all("zero_done", 1'b0, 3'd0, 1'b0, 1'b1, ec(0));
    step(); chk_all("zero_after", 1'b0, 3'd0, 1'b0, 1'b0, ec(0));

    // 0xFF with an ignored load at the third index.
    in = 8'hFF; load = 1'b1;
    step(); load = 1'b0;
    chk_all("ff_i0", 1'b1, 3'd0, 1'b0, 1'b0, ec(0));
    step(); chk_all("ff_i1", 1'b1, 3'd1, 1'b0, 1'b0, ec(1));
    step(); chk_all("ff_i2", 1'b1, 3'd2, 1'b0, 1'b0, ec(2));
    in = 8'h01; load = 1'b1;
    step(); load = 1'b0; in = 8'h00;
    chk_all("ff_i3", 1'b1, 3'd3, 1'b0, 1'b0, ec(3));
    step(); chk_all("ff_i4", 1'b1, 3'd4, 1'b0, 1'b0, ec(4));
    step(); chk_all("ff_i5", 1'b1, 3'd5, 1'b0, 1'b0, ec(5));
    step(); chk_all("ff_i6", 1'b1, 3'd6, 1'b0, 1'b0, ec(6));
    step(); chk_all("ff_i7", 1'b1, 3'd7, 1'b1, 1'b0, ec(7));
    step(); chk_all("ff_done", 1'b0, 3'd0, 1'b0, 1'b1, ec(8));

    // Load while done is high is accepted.
    in = 8'h10; load = 1'b1;
    step(); load = 1'b0; in = 8'h00;
    chk_all("dl_i4", 1'b1, 3'd4, 1'b1, 1'b0, ec(0));
    step(); chk_all("dl_done", 1'b0, 3'd0, 1'b0, 1'b1, ec(1));
    step(); chk_all("dl_after", 1'b0, 3'd0, 1'b0, 1'b0, ec(1));

    // Reset mid-drain of 0xF0.
    in = 8'hF0; load = 1'b1;
    step(); load = 1'b0; in = 8'h00;
    chk_all("rs_i4", 1'b1, 3'd4, 1'b0, 1'b0, ec(0));
    step(); chk_all("rs_i5", 1'b1, 3'd5, 1'b0, 1'b0, ec(1));
    #2 rst_n = 1'b0;
    #1 chk_all("rs_async", 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
    step(); chk_all("rs_held", 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
    rst_n = 1'b1;
    step(); chk_all("rs_rel", 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
    in = 8'h80; load = 1'b1;
    step(); load = 1'b0; in = 8'h00;
    chk_all("rs_i7", 1'b1, 3'd7, 1'b1, 1'b0, ec(0));
    step(); chk_all("rs_done", 1'b0, 3'd0, 1'b0, 1'b1, ec(1));

    // 0x0F drain with count tracking.
    in = 8'h0F; load = 1'b1;
    step(); load = 1'b0; in = 8'h00;
    chk_all("f_i0", 1'b1, 3'd0, 1'b0, 1'b0, ec(0));
    step(); chk_all("f_i1", 1'b1, 3'd1, 1'b0, 1'b0, ec(1));
    step(); chk_all("f_i2", 1'b1, 3'd2, 1'b0, 1'b0, ec(2));
    step(); chk_all("f_i3", 1'b1, 3'd3, 1'b1, 1'b0, ec(3));
    step(); chk_all("f_done", 1'b0, 3'd0, 1'b0, 1'b1, ec(4));
    step(); chk_all("f_after", 1'b0, 3'd0, 1'b0, 1'b0, ec(4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_um_jleugeri_ttt_event_drain.md
TT_UM_JLEUGERI_TTT_EVENT_DRAIN -- requirements
Module: tt_um_jleugeri_ttt_event_drain

Interface
REQ-001 SHALL have parameter SIZE, default 8, bit-vector width; power of two, at least 2.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in, input, SIZE bits: event bit vector, sampled only on an accepted load.
REQ-005 SHALL have port load, input, 1 bit: request to snapshot in.
REQ-006 SHALL have port busy, output, 1 bit: snapshot held, drain in progress.
REQ-007 SHALL have port out_valid, output, 1 bit: out_idx carries a pending set-bit index.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts out_idx.
REQ-009 SHALL have port out_idx, output, $clog2(SIZE) bits: index of the lowest pending set bit.
REQ-010 SHALL have port out_last, output, 1 bit: the current index is the final pending bit.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a drain completes.
REQ-012 SHALL have port count, output, $clog2(SIZE)+1 bits: indices emitted since the last load (see Configuration).

Function
REQ-013 SHALL have two states: IDLE and EMIT.
REQ-014 IDLE with load=1 SHALL capture in into pending at the clock edge; nonzero pending -> EMIT, zero pending -> stay in IDLE and pulse done next cycle.
REQ-015 busy SHALL equal (state==EMIT), registered.
REQ-016 out_valid SHALL equal busy; valid first appears the cycle after the load edge (1-cycle latency).
REQ-017 out_idx SHALL be the lowest-numbered set bit of pending, combinational from pending.
REQ-018 out_last SHALL be 1 iff pending has exactly one set bit, qualified by out_valid.
REQ-019 Handshake SHALL be out_valid & out_ready; on handshake, clear bit out_idx of pending.
REQ-020 If a handshake happens while out_last=1, SHALL return to IDLE and pulse done for exactly the following cycle.
REQ-021 Without a handshake, out_idx, out_last and pending SHALL hold stable; out_valid SHALL NOT drop before a handshake.
REQ-022 load during EMIT SHALL be ignored: no snapshot, no state change.
REQ-023 load in the cycle done is high (state IDLE) SHALL be accepted normally.
REQ-024 out_valid=0 SHALL force out_idx=0 and out_last=0.
REQ-025 Throughput SHALL be one index per cycle while out_ready=1.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, pending=0, busy=0, out_valid=0, out_idx=0, out_last=0, done=0, count=0.
REQ-027 Reset during EMIT SHALL abort the drain without a done pulse; on release, state is IDLE.

Configuration
REQ-028 Macro RESPITE_EVENT_COUNT_EN defined: count SHALL clear to 0 on an accepted load and increment on each handshake, saturating at SIZE.
REQ-029 Macro RESPITE_EVENT_COUNT_EN absent: port count SHALL still exist, tied to 0, with no counter register.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, EMIT) and the index-width helper constant.
REQ-031 A combinational sub-module, tt_um_jleugeri_ttt_lsb_find, SHALL produce the lowest-set index, nonempty and single-bit flags from pending.

Verification (SIZE=8)
REQ-032 load with in=8'b1010_0100, out_ready=1 -> out_idx 2,5,7 on three consecutive cycles; out_last only with 7; done pulses one cycle later; count=3 (macro on).
REQ-033 Same load with out_ready=0 for 4 cycles -> out_idx holds 2 with valid=1 throughout; after ready rises, 5 then 7 follow.
REQ-034 load with in=8'h00 -> out_valid never rises; done pulses once, the cycle after the load edge.
REQ-035 load 8'hFF; at the 3rd index, pulse load with in=8'h01 -> load ignored; sequence 0..7 completes; done pulses once.
REQ-036 rst_n pulsed low mid-drain of 8'hF0 -> outputs zero asynchronously, no done pulse; a following load of 8'h80 -> single index 7 with out_last=1.
REQ-037 Macro off, load 8'h0F and drain -> count stays 0 throughout.
